// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for a 640x480 @ 60 Hz VGA frame
// (800x525 total by default).
// The system clock is divided down to a pixel rate by div_cnt. Horizontal
// and vertical counters scan the frame. Sync and visible-area decodes are
// registered together with the coordinates, so the two never skew.
//
// Ports:
//   clk        - system clock, single clock domain
//   rst        - synchronous, active-high reset
//   pixel_x    - current horizontal count, 0..H_TOTAL-1
//   pixel_y    - current vertical count, 0..V_TOTAL-1
//   hsync      - horizontal sync, active low
//   vsync      - vertical sync, active low
//   video_on   - high while (pixel_x, pixel_y) is inside the visible area
//   pixel_tick - one-clk strobe, once per pixel period
//   frame_tick - one-clk strobe on the pixel_tick that wraps to (0,0)
module vga_sync_gen #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       pixel_tick,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [3:0] div_cnt;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   // Cleared by reset. The first edge after release keeps the divider at
   // phase 0, so every pixel (including (0,0)) gets a full divider period
   // once counting begins.
   logic       running;

   logic [3:0] div_next;
   logic [9:0] h_next;
   logic [9:0] v_next;
   logic       tick_next;
   logic       frame_next;
   logic       hsync_next;
   logic       vsync_next;
   logic       video_next;

   assign pixel_x = h_cnt;
   assign pixel_y = v_cnt;

   // Next-state computation for the divider, the raster counters and their decodes.
   always_comb begin
      div_next   = div_cnt;
      h_next     = h_cnt;
      v_next     = v_cnt;

      if (!running) begin
         div_next = 4'd0;
      end else if (div_cnt == DIV_LAST) begin
         div_next = 4'd0;
      end else begin
         div_next = div_cnt + 4'd1;
      end

      // The registered pixel_tick marks the last divider phase; the counters
      // step on the edge that ends that cycle.
      if (pixel_tick) begin
         if (h_cnt == H_LAST) begin
            h_next = 10'd0;
            if (v_cnt == V_LAST) begin
               v_next = 10'd0;
            end else begin
               v_next = v_cnt + 10'd1;
            end
         end else begin
            h_next = h_cnt + 10'd1;
         end
      end else begin
         h_next = h_cnt;
         v_next = v_cnt;
      end

      tick_next  = (div_next == DIV_LAST);
      frame_next = tick_next && (h_next == H_LAST) && (v_next == V_LAST);
      hsync_next = !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
      vsync_next = !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
      video_next = (h_next < H_VIS) && (v_next < V_VIS);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         running    <= 1'b0;
         div_cnt    <= 4'd0;
         h_cnt      <= 10'd0;
         v_cnt      <= 10'd0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         video_on   <= 1'b0;
         pixel_tick <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         running    <= 1'b1;
         div_cnt    <= div_next;
         h_cnt      <= h_next;
         v_cnt      <= v_next;
         hsync      <= hsync_next;
         vsync      <= vsync_next;
         video_on   <= video_next;
         pixel_tick <= tick_next;
         frame_tick <= frame_next;
      end
   end

endmodule
